// File: rtl/zero_uart_slave.sv
// zero_uart_slave: memory-mapped UART responder on the zerocore RAM port.
// TX bytes queue in a FIFO drained to uart_out; RXDATA reads fetch via uart_in.
module zero_uart_slave #(
    parameter logic [63:0] BASE_ADDR  = 64'h1000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          TX_GAP     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RamReadEnable,
    input  logic [63:0] RamReadAddr,
    output logic [63:0] RamReadData,
    output logic        RamReadHit,
    input  logic        RamWriteEnable,
    input  logic [63:0] RamWriteAddr,
    input  logic [63:0] RamWriteData,
    input  logic [63:0] RamWriteMask,
    output logic        uart_out_valid,
    output logic [7:0]  uart_out_ch,
    output logic        uart_in_valid,
    input  logic [7:0]  uart_in_ch
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0] GAP_LOAD = 8'(TX_GAP - 1);

    localparam logic [1:0] OFF_TX = 2'd0;
    localparam logic [1:0] OFF_ST = 2'd1;
    localparam logic [1:0] OFF_RX = 2'd2;
    localparam logic [1:0] OFF_CT = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [AW:0]   count;
    logic          ovf;
    logic          tx_en;
    logic [7:0]    gcnt;

    logic          rd_hit;
    logic          wr_hit;
    logic [1:0]    rd_off;
    logic [1:0]    wr_off;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic          ovf_set;
    logic          ctrl_wr;
    logic          flush;
    logic [7:0]    cnt8;
    logic [63:0]   rd_next;
    logic          unused;

    assign rd_hit = RamReadAddr[63:5] == BASE_ADDR[63:5];
    assign wr_hit = RamWriteAddr[63:5] == BASE_ADDR[63:5];
    assign rd_off = RamReadAddr[4:3];
    assign wr_off = RamWriteAddr[4:3];

    assign full  = count == DEPTH_C;
    assign empty = count == '0;
    assign cnt8  = 8'(count);

    assign pop = !empty && tx_en && gcnt == 8'd0;

    assign push_req = RamWriteEnable && wr_hit && wr_off == OFF_TX
                   && RamWriteMask[7:0] == 8'hFF;
    assign ctrl_wr  = RamWriteEnable && wr_hit && wr_off == OFF_CT;
    assign flush    = ctrl_wr && RamWriteMask[1] && RamWriteData[1];

    // a full FIFO still accepts a push when a pop frees the slot this cycle
    assign push_ok = push_req && !flush && (!full || pop);
    assign ovf_set = push_req && !flush && full && !pop;

    assign uart_in_valid = rst_n && RamReadEnable && rd_hit && rd_off == OFF_RX;

    assign unused = ^{RamReadAddr[2:0], RamWriteAddr[2:0],
                      RamWriteData[63:8], RamWriteMask[63:8]};

    // read mux over pre-write register state
    always_comb begin
        rd_next = '0;
        if (RamReadEnable && rd_hit) begin
            unique case (rd_off)
                OFF_TX: rd_next = '0;
                OFF_ST: rd_next = {48'b0, cnt8, 4'b0, tx_en, ovf, empty, full};
                OFF_RX: rd_next = {55'b0, uart_in_ch != 8'hFF, uart_in_ch};
                OFF_CT: rd_next = {63'b0, tx_en};
            endcase
        end
    end

    // FIFO storage, no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= RamWriteData[7:0];
    end

    // FIFO pointers, count, overflow flag, control and gap timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            tx_en <= 1'b1;
            gcnt  <= 8'd0;
        end else begin
            if (flush) begin
                rptr  <= '0;
                wptr  <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end else begin
                if (pop)     rptr <= rptr + 1'b1;
                if (push_ok) wptr <= wptr + 1'b1;
                count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
                if (ovf_set) ovf <= 1'b1;
            end
            if (ctrl_wr && RamWriteMask[0]) tx_en <= RamWriteData[0];
            if (pop)                gcnt <= GAP_LOAD;
            else if (gcnt != 8'd0)  gcnt <= gcnt - 8'd1;
        end
    end

    // registered read response and TX pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RamReadData    <= '0;
            RamReadHit     <= 1'b0;
            uart_out_valid <= 1'b0;
            uart_out_ch    <= 8'd0;
        end else begin
            RamReadData    <= rd_next;
            RamReadHit     <= RamReadEnable && rd_hit;
            uart_out_valid <= pop;
            if (pop) uart_out_ch <= mem[rptr];
        end
    end

endmodule
